// File: rtl/sm83_pkg.sv
// Shared SM83 datapath types: byte data, F register layout, ALU opcodes,
// and the 16-bit arithmetic sequencer's opcode and state encodings.
package sm83_pkg;

   typedef logic [7:0] data_t;

   typedef struct packed {
      logic z;
      logic n;
      logic h;
      logic c;
   } flags_t;

   typedef enum logic [3:0] {
      ALU_NOP = 4'd0,
      ALU_ADD = 4'd1,
      ALU_ADC = 4'd2,
      ALU_SUB = 4'd3,
      ALU_SBC = 4'd4,
      ALU_AND = 4'd5,
      ALU_XOR = 4'd6,
      ALU_OR  = 4'd7,
      ALU_CP  = 4'd8,
      ALU_INC = 4'd9,
      ALU_DEC = 4'd10
   } alu_op_t;

   typedef enum logic [1:0] {
      ALU16_ADD_HL = 2'd0,
      ALU16_ADD_SP = 2'd1,
      ALU16_INC    = 2'd2,
      ALU16_DEC    = 2'd3
   } alu16_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      RSP  = 2'd3
   } alu16_state_t;

   localparam flags_t FLAGS_CLR = '0;

   // Upper byte of a sign-extended 8-bit displacement
   function automatic data_t sign_fill(input data_t e);
      return e[7] ? 8'hFF : 8'h00;
   endfunction

endpackage

// File: rtl/alu16_seq_if.sv
// Request/response handshake bundle between the control unit and the
// 16-bit arithmetic sequencer.
interface alu16_seq_if;
   import sm83_pkg::*;

   logic        req_valid;
   logic        req_ready;
   alu16_op_t   req_op;
   logic [15:0] req_a;
   logic [15:0] req_b;
   flags_t      req_flags;

   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_result;
   flags_t      rsp_flags;

   modport master (
      output req_valid,
      output req_op,
      output req_a,
      output req_b,
      output req_flags,
      output rsp_ready,
      input  req_ready,
      input  rsp_valid,
      input  rsp_result,
      input  rsp_flags
   );

   modport slave (
      input  req_valid,
      input  req_op,
      input  req_a,
      input  req_b,
      input  req_flags,
      input  rsp_ready,
      output req_ready,
      output rsp_valid,
      output rsp_result,
      output rsp_flags
   );

endinterface

// File: rtl/alu.sv
// Combinational SM83 8-bit ALU. INC/DEC report carry/borrow out on c so a
// 16-bit sequencer can chain bytes; F write-back masking is done upstream.
module alu
   import sm83_pkg::*;
(
   input  alu_op_t op,
   input  data_t   op1,
   input  data_t   op2,
   input  flags_t  in_flags,
   output data_t   result,
   output flags_t  out_flags
);

   logic [8:0] wide;
   logic [4:0] nib;
   logic       ci_add;
   logic       ci_sub;

   always_comb begin
      ci_add    = in_flags.c & (op == ALU_ADC);
      ci_sub    = in_flags.c & (op == ALU_SBC);
      wide      = '0;
      nib       = '0;
      result    = '0;
      out_flags = in_flags;
      unique case (op)
         ALU_ADD, ALU_ADC: begin
            wide = {1'b0, op1} + {1'b0, op2}
                 + {8'd0, ci_add};
            nib  = {1'b0, op1[3:0]} + {1'b0, op2[3:0]}
                 + {4'd0, ci_add};
            result    = wide[7:0];
            out_flags = '{z: (wide[7:0] == 8'd0),
                          n: 1'b0,
                          h: nib[4],
                          c: wide[8]};
         end
         ALU_SUB, ALU_SBC, ALU_CP: begin
            wide = {1'b0, op1} - {1'b0, op2}
                 - {8'd0, ci_sub};
            nib  = {1'b0, op1[3:0]} - {1'b0, op2[3:0]}
                 - {4'd0, ci_sub};
            result    = (op == ALU_CP) ? op1 : wide[7:0];
            out_flags = '{z: (wide[7:0] == 8'd0),
                          n: 1'b1,
                          h: nib[4],
                          c: wide[8]};
         end
         ALU_AND: begin
            result    = op1 & op2;
            out_flags = '{z: (result == 8'd0),
                          n: 1'b0, h: 1'b1, c: 1'b0};
         end
         ALU_XOR: begin
            result    = op1 ^ op2;
            out_flags = '{z: (result == 8'd0),
                          n: 1'b0, h: 1'b0, c: 1'b0};
         end
         ALU_OR: begin
            result    = op1 | op2;
            out_flags = '{z: (result == 8'd0),
                          n: 1'b0, h: 1'b0, c: 1'b0};
         end
         ALU_INC: begin
            wide      = {1'b0, op1} + 9'd1;
            result    = wide[7:0];
            out_flags = '{z: (wide[7:0] == 8'd0),
                          n: 1'b0,
                          h: (op1[3:0] == 4'hF),
                          c: wide[8]};
         end
         ALU_DEC: begin
            wide      = {1'b0, op1} - 9'd1;
            result    = wide[7:0];
            out_flags = '{z: (wide[7:0] == 8'd0),
                          n: 1'b1,
                          h: (op1[3:0] == 4'h0),
                          c: wide[8]};
         end
         default: begin
            result    = '0;
            out_flags = in_flags;
         end
      endcase
   end

endmodule

// File: rtl/alu16_seq.sv
// Runs SM83 16-bit ADD HL,rr / ADD SP,e / INC rr / DEC rr as two chained
// byte operations on the shared 8-bit ALU, low byte first.
module alu16_seq
   import sm83_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   alu16_seq_if.slave   bus,
   output alu_op_t      alu_op,
   output data_t        alu_op1,
   output data_t        alu_op2,
   output flags_t       alu_in_flags,
   input  data_t        alu_result,
   input  flags_t       alu_out_flags
);

   alu16_state_t state;
   alu16_state_t state_nx;

   alu16_op_t    op_q;
   logic [15:0]  a_q;
   logic [15:0]  b_q;
   flags_t       f_q;

   data_t        res_lo;
   data_t        res_hi;
   logic         c_lo;
   flags_t       flags_q;
   flags_t       flags_nx;

   logic [12:0]  sum12;
   logic [4:0]   sum4;
   logic         c_hi;
   logic         unused_alu_flags;

   assign unused_alu_flags = ^{alu_out_flags.z,
                               alu_out_flags.n,
                               alu_out_flags.h};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (bus.req_valid) state_nx = LO;
         LO:   state_nx = HI;
         HI:   state_nx = RSP;
         RSP:  if (bus.rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      alu_op       = ALU_NOP;
      alu_op1      = '0;
      alu_op2      = '0;
      alu_in_flags = FLAGS_CLR;
      unique case (state)
         LO: begin
            alu_op1 = a_q[7:0];
            unique case (op_q)
               ALU16_ADD_HL,
               ALU16_ADD_SP: begin
                  alu_op  = ALU_ADD;
                  alu_op2 = b_q[7:0];
               end
               ALU16_INC: alu_op = ALU_INC;
               ALU16_DEC: alu_op = ALU_DEC;
               default:   alu_op = ALU_NOP;
            endcase
         end
         HI: begin
            alu_op1        = a_q[15:8];
            alu_in_flags.c = c_lo;
            unique case (op_q)
               ALU16_ADD_HL: begin
                  alu_op  = ALU_ADC;
                  alu_op2 = b_q[15:8];
               end
               ALU16_ADD_SP: begin
                  alu_op  = ALU_ADC;
                  alu_op2 = sign_fill(b_q[7:0]);
               end
               ALU16_INC: alu_op = ALU_ADC;
               ALU16_DEC: alu_op = ALU_SBC;
               default:   alu_op = ALU_NOP;
            endcase
         end
         default: ;
      endcase
   end

   // Half-carry comes from the latched operands, not from the ALU's byte H
   always_comb begin
      sum12 = {1'b0, a_q[11:0]} + {1'b0, b_q[11:0]};
      sum4  = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]};
      c_hi  = alu_out_flags.c;
      unique case (op_q)
         ALU16_ADD_HL:
            flags_nx = '{z: f_q.z, n: 1'b0,
                         h: sum12[12], c: c_hi};
         ALU16_ADD_SP:
            flags_nx = '{z: 1'b0, n: 1'b0,
                         h: sum4[4], c: c_lo};
         default:
            flags_nx = f_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q    <= ALU16_ADD_HL;
         a_q     <= '0;
         b_q     <= '0;
         f_q     <= FLAGS_CLR;
         res_lo  <= '0;
         res_hi  <= '0;
         c_lo    <= 1'b0;
         flags_q <= FLAGS_CLR;
      end else begin
         unique case (state)
            IDLE: if (bus.req_valid) begin
               op_q <= bus.req_op;
               a_q  <= bus.req_a;
               b_q  <= bus.req_b;
               f_q  <= bus.req_flags;
            end
            LO: begin
               res_lo <= alu_result;
               c_lo   <= alu_out_flags.c;
            end
            HI: begin
               res_hi  <= alu_result;
               flags_q <= flags_nx;
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready  = (state == IDLE) & ~rst;
   assign bus.rsp_valid  = (state == RSP);
   assign bus.rsp_result = {res_hi, res_lo};
   assign bus.rsp_flags  = flags_q;

endmodule

// File: tb/tb_alu16_seq.sv
// Scoreboard bench for alu16_seq driving a real 8-bit ALU: directed corner
// cases, randomized ops with random backpressure, stall and reset-abort.
module tb_alu16_seq;
   import sm83_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu16_seq_if bus();

   alu_op_t alu_op;
   data_t   alu_op1;
   data_t   alu_op2;
   data_t   alu_result;
   flags_t  alu_in_flags;
   flags_t  alu_out_flags;

   alu16_seq dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .alu_op        (alu_op),
      .alu_op1       (alu_op1),
      .alu_op2       (alu_op2),
      .alu_in_flags  (alu_in_flags),
      .alu_result    (alu_result),
      .alu_out_flags (alu_out_flags)
   );

   alu u_alu (
      .op        (alu_op),
      .op1       (alu_op1),
      .op2       (alu_op2),
      .in_flags  (alu_in_flags),
      .result    (alu_result),
      .out_flags (alu_out_flags)
   );

   typedef struct packed {
      logic [15:0] r;
      flags_t      f;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic exp_t model(alu16_op_t op, logic [15:0] a,
                                  logic [15:0] b, flags_t f);
      exp_t e;
      int   s;
      int   ev;
      e.f = f;
      case (op)
         ALU16_ADD_HL: begin
            s     = int'(a) + int'(b);
            e.r   = 16'(s);
            e.f.n = 1'b0;
            e.f.h = (int'(a[11:0]) + int'(b[11:0])) > 4095;
            e.f.c = s > 65535;
         end
         ALU16_ADD_SP: begin
            ev    = b[7] ? int'(b[7:0]) - 256 : int'(b[7:0]);
            e.r   = 16'(int'(a) + ev);
            e.f.z = 1'b0;
            e.f.n = 1'b0;
            e.f.h = (int'(a[3:0]) + int'(b[3:0])) > 15;
            e.f.c = (int'(a[7:0]) + int'(b[7:0])) > 255;
         end
         ALU16_INC: e.r = 16'(int'(a) + 1);
         default:   e.r = 16'(int'(a) - 1);
      endcase
      return e;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && bus.rsp_valid && bus.rsp_ready) begin
         if (sbq.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_rsp: got %h with empty queue @%0t",
                     bus.rsp_result, $time);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("rsp_result", 32'(bus.rsp_result), 32'(e.r));
            chk("rsp_flags", 32'(bus.rsp_flags), 32'(e.f));
         end
      end
   end

   task automatic send(alu16_op_t op, logic [15:0] a, logic [15:0] b,
                       flags_t f, bit rnd);
      bit acc;
      int k;
      acc = 1'b0;
      k   = 0;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.req_flags = f;
      do begin
         @(negedge clk);
         acc = bus.req_ready;
         @(posedge clk);
         #1;
         if (rnd) bus.rsp_ready = ($urandom_range(0, 3) != 0);
         k++;
      end while (!acc && k < 200);
      if (!acc) begin
         n_cmp++;
         n_err++;
         $display("FAIL accept_timeout: got no accept expected accept");
      end else begin
         sbq.push_back(model(op, a, b, f));
      end
      bus.req_valid = 1'b0;
      bus.req_op    = alu16_op_t'($urandom_range(0, 3));
      bus.req_a     = 16'($urandom);
      bus.req_b     = 16'($urandom);
      bus.req_flags = flags_t'(4'($urandom));
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (sbq.size() != 0 && k < 200) begin
         @(posedge clk);
         k++;
      end
      #1;
      if (sbq.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain_timeout: got %0d pending expected 0",
                  sbq.size());
         sbq.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      exp_t e1;
      bus.req_valid = 1'b0;
      bus.req_op    = ALU16_ADD_HL;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_flags = FLAGS_CLR;
      bus.rsp_ready = 1'b1;

      #2;
      chk("rst_req_ready", 32'(bus.req_ready), 0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst_rsp_result", 32'(bus.rsp_result), 0);
      chk("rst_rsp_flags", 32'(bus.rsp_flags), 0);
      chk("rst_alu_op", 32'(alu_op), 32'(ALU_NOP));
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("idle_req_ready", 32'(bus.req_ready), 1);
      @(posedge clk);
      #1;

      send(ALU16_ADD_HL, 16'h0FFF, 16'h0001, 4'b1000, 1'b0);
      @(negedge clk);
      chk("lat_c1", 32'(bus.rsp_valid), 0);
      @(negedge clk);
      chk("lat_c2", 32'(bus.rsp_valid), 0);
      @(negedge clk);
      chk("lat_c3", 32'(bus.rsp_valid), 1);
      drain();

      send(ALU16_ADD_HL, 16'hFFFF, 16'h0001, 4'b0000, 1'b0); drain();
      send(ALU16_ADD_SP, 16'h00FF, 16'h0001, 4'b1111, 1'b0); drain();
      send(ALU16_ADD_SP, 16'h0001, 16'h00FF, 4'b0000, 1'b0); drain();
      send(ALU16_INC, 16'hFFFF, 16'h0000, 4'b1111, 1'b0); drain();
      send(ALU16_DEC, 16'h0000, 16'h0000, 4'b1111, 1'b0); drain();
      send(ALU16_DEC, 16'h0100, 16'h0000, 4'b1111, 1'b0); drain();
      send(ALU16_INC, 16'h00FE, 16'h0000, 4'b0101, 1'b0); drain();

      for (int i = 0; i < 40; i++) begin
         send(alu16_op_t'($urandom_range(0, 3)), 16'($urandom),
              16'($urandom), flags_t'(4'($urandom)), 1'b1);
      end
      bus.rsp_ready = 1'b1;
      drain();

      // Stall the response while a second request waits
      bus.rsp_ready = 1'b0;
      e1 = model(ALU16_ADD_HL, 16'h8888, 16'h8888, 4'b1000);
      send(ALU16_ADD_HL, 16'h8888, 16'h8888, 4'b1000, 1'b0);
      bus.req_valid = 1'b1;
      bus.req_op    = ALU16_ADD_SP;
      bus.req_a     = 16'h1000;
      bus.req_b     = 16'hAB80;
      bus.req_flags = 4'b1111;
      repeat (3) @(negedge clk);
      chk("bp_valid", 32'(bus.rsp_valid), 1);
      for (int i = 0; i < 5; i++) begin
         chk("bp_result", 32'(bus.rsp_result), 32'(e1.r));
         chk("bp_flags", 32'(bus.rsp_flags), 32'(e1.f));
         chk("bp_req_ready", 32'(bus.req_ready), 0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_hs_req_ready", 32'(bus.req_ready), 0);
      @(posedge clk);
      #1 sbq.push_back(model(ALU16_ADD_SP, 16'h1000, 16'hAB80, 4'b1111));
      @(negedge clk);
      chk("bp_after_hs_ready", 32'(bus.req_ready), 1);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      chk("bp_accepted", 32'(bus.req_ready), 0);
      drain();

      // Abort an op while it is in its high-byte cycle
      send(ALU16_ADD_HL, 16'hFFFF, 16'hFFFF, 4'b0000, 1'b0);
      @(posedge clk);
      #1;
      chk("hi_alu_op", 32'(alu_op), 32'(ALU_ADC));
      rst = 1'b1;
      #1;
      chk("ar_req_ready", 32'(bus.req_ready), 0);
      chk("ar_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("ar_rsp_result", 32'(bus.rsp_result), 0);
      chk("ar_rsp_flags", 32'(bus.rsp_flags), 0);
      chk("ar_alu_op", 32'(alu_op), 32'(ALU_NOP));
      chk("ar_alu_ops", 32'({alu_op1, alu_op2, alu_in_flags}), 0);
      sbq.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("ar_post_ready", 32'(bus.req_ready), 1);
      repeat (5) @(negedge clk);
      chk("ar_no_rsp", 32'(bus.rsp_valid), 0);
      @(posedge clk);
      #1;
      send(ALU16_ADD_HL, 16'h1234, 16'h1111, 4'b0000, 1'b0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu16_seq.md
# alu16_seq

Two-cycle sequencer that executes the SM83 16-bit arithmetic instructions (ADD HL,rr; ADD SP,e; INC rr; DEC rr) by driving the 8-bit ALU twice: low byte first, then high byte with the carry chained. It sits directly upstream of the 8-bit ALU. It accepts a request from the control unit over a valid/ready handshake, owns the ALU's input ports while busy, and returns a 16-bit result plus final flags over a second valid/ready handshake.

## Interface
Parameters:
- none (widths fixed by `sm83_pkg`: `data_t` is 8 bits)

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  sequencer idle, can accept
- `req_op`  in  `alu16_op_t`  ALU16_ADD_HL / ALU16_ADD_SP / ALU16_INC / ALU16_DEC
- `req_a`  in  16  first operand (HL, SP, or rr)
- `req_b`  in  16  second operand (rr); for ADD_SP, `[7:0]` = signed e, `[15:8]` ignored
- `req_flags`  in  `flags_t`  current F register
- `alu_op`  out  `alu_op_t`  to ALU
- `alu_op1`, `alu_op2`  out  `data_t`  to ALU
- `alu_in_flags`  out  `flags_t`  to ALU (carry chaining)
- `alu_result`  in  `data_t`  from ALU
- `alu_out_flags`  in  `flags_t`  from ALU (only `.c` is used)
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  consumer accepts result
- `rsp_result`  out  16  16-bit result
- `rsp_flags`  out  `flags_t`  F value to write back

## Operation
- FSM states: IDLE, LO, HI, RSP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch op, a, b, and flags, then go to LO.
- LO: drive the low byte to the ALU, register `alu_result` into `res_lo` and `alu_out_flags.c` into `c_lo`, then go to HI.
  - ADD_HL: ADD(a_lo, b_lo).
  - ADD_SP: ADD(a_lo, e).
  - INC: INC(a_lo).
  - DEC: DEC(a_lo).
- HI: drive the high byte with `alu_in_flags.c` = `c_lo` (all other `alu_in_flags` bits 0), register `res_hi` and `c_hi`, compute flags, then go to RSP.
  - ADD_HL: ADC(a_hi, b_hi).
  - ADD_SP: ADC(a_hi, e[7] ? 8'hFF : 8'h00).
  - INC: ADC(a_hi, 0).
  - DEC: SBC(a_hi, 0).
- RSP: hold `rsp_valid`=1 with `rsp_result`={res_hi,res_lo} stable until `rsp_ready`, then go to IDLE.
- ALU drive outside LO/HI: `alu_op`=ALU_NOP, operands 0, `alu_in_flags` 0.
- Flag rules. H is computed locally from latched operands; the ALU's H is not used.
  - ADD_HL: z = latched z; n=0; h = carry out of bit 11 of a+b; c = `c_hi`.
  - ADD_SP: z=0; n=0; h = carry out of bit 3 of a_lo+e; c = `c_lo`.
  - INC/DEC: `rsp_flags` = latched flags, unchanged.
- Arithmetic wraps modulo 2^16.

## Timing
- Reset (async, immediate):
  - state=IDLE.
  - `rsp_valid`=0, `rsp_result`=0, `rsp_flags`=0.
  - `req_ready`=0 while `rst` is high, 1 after release.
  - ALU outputs at NOP/0.
- Accept at edge N:
  - LO during cycle N+1.
  - HI during cycle N+2.
  - `rsp_valid`=1 from cycle N+3.
- Minimum occupancy is 4 cycles per op: no accept during LO/HI/RSP, including the RSP handshake cycle.
- `req_*` are sampled only at the accepting edge; later changes are ignored.
- RSP with `rsp_ready`=0 stalls indefinitely with outputs stable.
- Reset mid-operation (any state) aborts the op; no response is produced.

## Structure
- `sm83_pkg` additions: `alu16_op_t` enum (2 bits: ALU16_ADD_HL=0, ALU16_ADD_SP=1, ALU16_INC=2, ALU16_DEC=3) and `alu16_state_t` (IDLE, LO, HI, RSP).
- Reuses `data_t`, `flags_t`, `alu_op_t`.
- No sub-module. The ALU is instantiated beside this block by the integrating level, not inside it.
- Bench instantiates `alu16_seq` and `alu` together.

## Test plan
- ADD_HL, a=0x0FFF, b=0x0001, flags z=1 → result 0x1000, flags z=1 n=0 h=1 c=0. `rsp_valid` rises exactly 3 cycles after the accept edge.
- ADD_HL, a=0xFFFF, b=0x0001, flags z=0 → result 0x0000, flags z=0 n=0 h=1 c=1 (Z not set by a zero result).
- ADD_SP:
  - a=0x00FF, b=0x0001 → 0x0100, flags z=0 n=0 h=1 c=1.
  - a=0x0001, b=0x00FF (e=-1) → 0x0000, flags z=0 n=0 h=1 c=1.
- INC/DEC, input flags 0xF (z, n, h, c all set):
  - INC a=0xFFFF → 0x0000.
  - DEC a=0x0000 → 0xFFFF.
  - DEC a=0x0100 → 0x00FF.
  - `rsp_flags` unchanged in every case.
- Backpressure: hold `rsp_ready`=0 for 5 cycles while `req_valid`=1 with a second request → `rsp_result`/`rsp_flags` stable, `req_ready`=0, second request not accepted until 1 cycle after the response handshake.
- Assert `rst` during HI → outputs go to reset values without waiting for a clock edge. After release, `req_ready`=1, no `rsp_valid` appears, and a fresh ADD_HL 0x1234+0x1111 returns 0x2345 with h=0 c=0.
